// File: rtl/param_bist.sv
// Parameterised logic BIST: a Galois LFSR drives a W-bit adder, a MISR compacts its results,
// and the final signature is compared to GOLDEN. Optional macro BIST_FAULT_INJECT_EN adds port inj.
module param_bist #(
  parameter int               W      = 8,
  parameter int               NPAT   = 255,
  parameter logic [2*W-1:0]   SEED   = 16'h0001,
  parameter logic [2*W-1:0]   POLY   = 16'h002D,
  parameter logic [W-1:0]     MPOLY  = 8'h1D,
  parameter logic [W-1:0]     GOLDEN = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             testmode,
  input  logic             start,
`ifdef BIST_FAULT_INJECT_EN
  input  logic             inj,
`endif
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic [W-1:0]     z,
  output logic [2*W-1:0]   e,
  output logic [W-1:0]     d,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  // Handshake: start is a one-cycle request sampled only in IDLE or DONE while testmode=1;
  // busy stays high from the first pattern until the compare cycle, done/pass are level outputs.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2*W-1:0] LAST = (2*W)'(NPAT - 1);

  state_t         state_q, state_d;
  logic [2*W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] e_d;
  logic [W-1:0]   d_d;
  logic           done_d, pass_d;

  logic [W-1:0]   a, b, z_raw;
  logic [W-1:0]   d_step;
  logic [2*W-1:0] e_step;

  // Circuit under test: operands come from the pins or from the LFSR halves.
  assign a     = testmode ? e[W-1:0]   : x;
  assign b     = testmode ? e[2*W-1:W] : y;
  assign z_raw = a + b;

`ifdef BIST_FAULT_INJECT_EN
  assign z = (testmode && inj) ? (z_raw | W'(1)) : z_raw;
`else
  assign z = z_raw;
`endif

  assign d_step = {d[W-2:0], 1'b0} ^ (d[W-1] ? MPOLY : '0) ^ z;
  assign e_step = {e[2*W-2:0], 1'b0} ^ (e[2*W-1] ? POLY : '0);

  assign busy = (state_q == RUN) || (state_q == CMP);

  always_comb begin
    state_d = state_q;
    e_d     = e;
    d_d     = d;
    cnt_d   = cnt_q;
    done_d  = done;
    pass_d  = pass;
    case (state_q)
      IDLE: begin
        if (start && testmode) begin
          state_d = RUN;
          e_d     = SEED;
          d_d     = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (!testmode) begin
          state_d = IDLE;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          d_d   = d_step;
          e_d   = e_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = CMP;
        end
      end
      CMP: begin
        if (!testmode) begin
          state_d = IDLE;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          pass_d  = (d == GOLDEN);
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Leaving test mode keeps the last verdict visible in IDLE.
        if (!testmode) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
          e_d     = SEED;
          d_d     = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      e       <= '0;
      d       <= '0;
      cnt_q   <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state_q <= state_d;
      e       <= e_d;
      d       <= d_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
      pass    <= pass_d;
    end
  end

endmodule
